// File: rtl/mem_stage.sv
// MEM pipeline stage: aligns load data, selects the multiplier half and drives WB and the forwarding bus.
// SRAM data and the product are captured on the entry cycle so a WB stall cannot lose them.
module mem_stage #(
    parameter int ES2MS_W = 78,
    parameter int MS2WS_W = 70,
    parameter int FWD_W   = 38
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               es2ms_valid,
    output logic               ms_allowin,
    input  logic [ES2MS_W-1:0] es2ms_bus,
    input  logic               es_res_from_mul,
    input  logic [67:0]        mul_result,
    input  logic [31:0]        data_sram_rdata,
    input  logic               ws_allowin,
    output logic               ms2ws_valid,
    output logic [MS2WS_W-1:0] ms2ws_bus,
    output logic [FWD_W-1:0]   mem_forward_zip
);
    logic               ms_valid_q, ms_valid_d;
    logic               first_q, first_d;
    logic [ES2MS_W-1:0] bus_q, bus_d;
    logic               res_from_mul_q, res_from_mul_d;
    logic [31:0]        rdata_hold_q, rdata_hold_d;
    logic [63:0]        mul_hold_q, mul_hold_d;

    logic        gr_we;
    logic [4:0]  dest;
    logic [4:0]  load_op;
    logic [31:0] alu_result;
    logic [2:0]  mul_op;
    logic [31:0] pc;
    logic [31:0] rdata_sel;
    logic [63:0] prod_sel;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic [31:0] mul_val;
    logic [31:0] final_result;
    logic        unused_mul_hi;

    assign gr_we      = bus_q[0];
    assign dest       = bus_q[5:1];
    assign load_op    = bus_q[10:6];
    assign alu_result = bus_q[42:11];
    assign mul_op     = bus_q[45:43];
    assign pc         = bus_q[ES2MS_W-1:46];

    assign ms_allowin    = ~ms_valid_q | ws_allowin;
    assign ms2ws_valid   = ms_valid_q;
    assign unused_mul_hi = ^mul_result[67:64];

    always_comb begin
        ms_valid_d     = ms_valid_q;
        first_d        = first_q;
        bus_d          = bus_q;
        res_from_mul_d = res_from_mul_q;
        rdata_hold_d   = rdata_hold_q;
        mul_hold_d     = mul_hold_q;
        if (ms_allowin)
            ms_valid_d = es2ms_valid;
        if (es2ms_valid && ms_allowin) begin
            bus_d          = es2ms_bus;
            res_from_mul_d = es_res_from_mul;
            first_d        = 1'b1;
        end else if (ms_valid_q) begin
            first_d = 1'b0;
        end
        // Late operands are only valid on the entry cycle; freeze them for the rest of a stall.
        if (ms_valid_q && first_q) begin
            rdata_hold_d = data_sram_rdata;
            mul_hold_d   = mul_result[63:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q     <= 1'b0;
            first_q        <= 1'b0;
            bus_q          <= '0;
            res_from_mul_q <= 1'b0;
            rdata_hold_q   <= '0;
            mul_hold_q     <= '0;
        end else begin
            ms_valid_q     <= ms_valid_d;
            first_q        <= first_d;
            bus_q          <= bus_d;
            res_from_mul_q <= res_from_mul_d;
            rdata_hold_q   <= rdata_hold_d;
            mul_hold_q     <= mul_hold_d;
        end
    end

    assign rdata_sel = first_q ? data_sram_rdata  : rdata_hold_q;
    assign prod_sel  = first_q ? mul_result[63:0] : mul_hold_q;

    always_comb begin
        case (alu_result[1:0])
            2'd0:    ld_byte = rdata_sel[7:0];
            2'd1:    ld_byte = rdata_sel[15:8];
            2'd2:    ld_byte = rdata_sel[23:16];
            default: ld_byte = rdata_sel[31:24];
        endcase
        ld_half = alu_result[1] ? rdata_sel[31:16] : rdata_sel[15:0];

        if (load_op[0])      load_val = {{24{ld_byte[7]}}, ld_byte};
        else if (load_op[3]) load_val = {24'd0, ld_byte};
        else if (load_op[1]) load_val = {{16{ld_half[15]}}, ld_half};
        else if (load_op[4]) load_val = {16'd0, ld_half};
        else                 load_val = rdata_sel;

        mul_val = mul_op[0] ? prod_sel[31:0] : prod_sel[63:32];

        if (|load_op)            final_result = load_val;
        else if (res_from_mul_q) final_result = mul_val;
        else                     final_result = alu_result;
    end

    assign ms2ws_bus       = {pc, final_result, dest, gr_we};
    assign mem_forward_zip = {ms_valid_q & gr_we, dest, final_result};
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of WB transfers plus inline stage-state checks.
module tb_mem_stage;
    logic        clk;
    logic        resetn;
    logic        es2ms_valid;
    logic        ms_allowin;
    logic [77:0] es2ms_bus;
    logic        es_res_from_mul;
    logic [67:0] mul_result;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms2ws_valid;
    logic [69:0] ms2ws_bus;
    logic [37:0] mem_forward_zip;

    int total = 0;
    int bad   = 0;
    logic [69:0] exp_q[$];

    localparam logic [4:0] LD_B  = 5'b00001;
    localparam logic [4:0] LD_H  = 5'b00010;
    localparam logic [4:0] LD_W  = 5'b00100;
    localparam logic [4:0] LD_BU = 5'b01000;
    localparam logic [4:0] LD_HU = 5'b10000;
    localparam logic [2:0] MUL_W   = 3'b001;
    localparam logic [2:0] MULH_W  = 3'b010;
    localparam logic [2:0] MULH_WU = 3'b100;
    localparam logic [67:0] PROD = 68'h1_2345_6789_0000_0001;

    mem_stage dut (
        .clk(clk), .resetn(resetn), .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
        .es2ms_bus(es2ms_bus), .es_res_from_mul(es_res_from_mul), .mul_result(mul_result),
        .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin), .ms2ws_valid(ms2ws_valid),
        .ms2ws_bus(ms2ws_bus), .mem_forward_zip(mem_forward_zip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic send(input logic [31:0] pc, input logic [2:0] mop, input logic [31:0] alu,
                        input logic [4:0] lop, input logic [4:0] dst, input logic we,
                        input logic rfm, input logic [31:0] exp_res);
        es2ms_valid     = 1'b1;
        es2ms_bus       = {pc, mop, alu, lop, dst, we};
        es_res_from_mul = rfm;
        exp_q.push_back({pc, exp_res, dst, we});
    endtask

    // Settle, retire a transfer into the scoreboard if one happens at the coming edge, move to next negedge.
    task automatic cyc();
        logic [69:0] e;
        #1;
        if (ms2ws_valid && ws_allowin) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got=%h", ms2ws_bus);
            end else begin
                e = exp_q.pop_front();
                if (ms2ws_bus !== e) begin
                    bad++;
                    $display("FAIL sb_bus got=%h exp=%h", ms2ws_bus, e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic sb_drained(input string tag);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s pending=%0d exp=0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_idle(input string tag);
        #1;
        total++;
        if (ms2ws_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s valid got=%b exp=0", tag, ms2ws_valid);
        end
    endtask

    // Issue one instruction, present late operands on its first MEM cycle; ws_allowin held high.
    task automatic issue(input logic [31:0] pc, input logic [2:0] mop, input logic [31:0] alu,
                         input logic [4:0] lop, input logic rfm, input logic [31:0] rd,
                         input logic [31:0] exp_res);
        send(pc, mop, alu, lop, 5'd9, 1'b1, rfm, exp_res);
        cyc();
        es2ms_valid     = 1'b0;
        data_sram_rdata = rd;
        mul_result      = PROD;
        cyc();
        data_sram_rdata = '0;
        mul_result      = '0;
    endtask

    task automatic test_reset();
        #1;
        total += 3;
        if (ms2ws_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ms2ws_valid); end
        if (mem_forward_zip[37] !== 1'b0) begin bad++; $display("FAIL rst_rf_we got=%b exp=0", mem_forward_zip[37]); end
        if (ms_allowin !== 1'b1) begin bad++; $display("FAIL rst_allowin got=%b exp=1", ms_allowin); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        ws_allowin = 1'b1;
        issue(32'h1000_0000, 3'b0, 32'h0000_1003, LD_B, 1'b0, 32'h80FF_1234, 32'hFFFF_FF80);
        check_idle("ldb_one_cycle");
        issue(32'h1000_0004, 3'b0, 32'h0000_1002, LD_HU, 1'b0, 32'h8001_7FFF, 32'h0000_8001);
        issue(32'h1000_0008, 3'b0, 32'h0000_1002, LD_H, 1'b0, 32'h8001_7FFF, 32'hFFFF_8001);
        issue(32'h1000_000C, 3'b0, 32'h0000_1001, LD_BU, 1'b0, 32'h80FF_1234, 32'h0000_0012);
        issue(32'h1000_0010, 3'b0, 32'h0000_1000, LD_B, 1'b0, 32'h80FF_1234, 32'h0000_0034);
        issue(32'h1000_0014, 3'b0, 32'h0000_1002, LD_B, 1'b0, 32'h80FF_1234, 32'hFFFF_FFFF);
        issue(32'h1000_0018, 3'b0, 32'h0000_1003, LD_HU, 1'b0, 32'h8001_7FFF, 32'h0000_8001);
        issue(32'h1000_001C, 3'b0, 32'h0000_1001, LD_H, 1'b0, 32'h8001_7FFF, 32'h0000_7FFF);
        // Load takes priority over a multiplier flag.
        issue(32'h1000_0020, MUL_W, 32'h0000_1000, LD_W, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        sb_drained("load_drain");
    endtask

    task automatic test_stall();
        ws_allowin = 1'b0;
        send(32'h2000_0000, 3'b0, 32'h0000_2000, LD_W, 5'd4, 1'b1, 1'b0, 32'hDEAD_BEEF);
        cyc();
        es2ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_sram_rdata = (i == 0) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            total += 3;
            if (ms2ws_bus[37:6] !== 32'hDEAD_BEEF) begin
                bad++; $display("FAIL stall_data cyc=%0d got=%h exp=deadbeef", i, ms2ws_bus[37:6]);
            end
            if (ms_allowin !== 1'b0) begin bad++; $display("FAIL stall_allowin cyc=%0d got=%b exp=0", i, ms_allowin); end
            if (ms2ws_valid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", i, ms2ws_valid); end
            cyc();
        end
        ws_allowin = 1'b1;
        cyc();
        check_idle("stall_single_xfer");
        sb_drained("stall_drain");
    endtask

    task automatic test_mul();
        ws_allowin = 1'b1;
        issue(32'h3000_0000, MULH_WU, 32'h0000_0055, 5'b0, 1'b1, 32'h0, 32'h2345_6789);
        issue(32'h3000_0004, MUL_W,   32'h0000_0055, 5'b0, 1'b1, 32'h0, 32'h0000_0001);
        issue(32'h3000_0008, MULH_W,  32'h0000_0055, 5'b0, 1'b1, 32'h0, 32'h2345_6789);
        // Product must survive a stall after the entry cycle.
        ws_allowin = 1'b0;
        send(32'h3000_000C, MULH_W, 32'h0, 5'b0, 5'd2, 1'b1, 1'b1, 32'h2345_6789);
        cyc();
        es2ms_valid = 1'b0;
        mul_result  = PROD;
        cyc();
        mul_result  = 68'hF_FFFF_FFFF_FFFF_FFFF;
        cyc();
        ws_allowin  = 1'b1;
        cyc();
        mul_result  = '0;
        sb_drained("mul_drain");
    endtask

    task automatic test_back_to_back();
        ws_allowin = 1'b1;
        send(32'h4000_0000, 3'b0, 32'h11, 5'b0, 5'd3, 1'b1, 1'b0, 32'h11);
        cyc();
        send(32'h4000_0004, 3'b0, 32'h22, 5'b0, 5'd4, 1'b0, 1'b0, 32'h22);
        #1;
        total += 2;
        if (ms2ws_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid0 got=%b exp=1", ms2ws_valid); end
        if (mem_forward_zip !== {1'b1, 5'd3, 32'h11}) begin
            bad++; $display("FAIL b2b_fwd0 got=%h exp=%h", mem_forward_zip, {1'b1, 5'd3, 32'h11});
        end
        cyc();
        es2ms_valid = 1'b0;
        #1;
        total += 2;
        if (ms2ws_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid1 got=%b exp=1", ms2ws_valid); end
        if (mem_forward_zip !== {1'b0, 5'd4, 32'h22}) begin
            bad++; $display("FAIL b2b_fwd1 got=%h exp=%h", mem_forward_zip, {1'b0, 5'd4, 32'h22});
        end
        cyc();
        check_idle("b2b_idle");
        sb_drained("b2b_drain");
    endtask

    task automatic test_reset_mid_stall();
        ws_allowin = 1'b0;
        send(32'h5000_0000, 3'b0, 32'h0000_5000, LD_W, 5'd6, 1'b1, 1'b0, 32'h1234_5678);
        cyc();
        es2ms_valid     = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        cyc();
        resetn = 1'b0;
        #1;
        total += 3;
        if (ms2ws_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", ms2ws_valid); end
        if (mem_forward_zip[37] !== 1'b0) begin bad++; $display("FAIL rstmid_rf_we got=%b exp=0", mem_forward_zip[37]); end
        if (ms_allowin !== 1'b1) begin bad++; $display("FAIL rstmid_allowin got=%b exp=1", ms_allowin); end
        exp_q.delete();
        cyc();
        resetn          = 1'b1;
        ws_allowin      = 1'b1;
        data_sram_rdata = '0;
        send(32'h5000_0004, 3'b0, 32'h55, 5'b0, 5'd7, 1'b1, 1'b0, 32'h55);
        cyc();
        es2ms_valid = 1'b0;
        #1;
        total++;
        if (mem_forward_zip !== {1'b1, 5'd7, 32'h55}) begin
            bad++; $display("FAIL rstmid_fwd got=%h exp=%h", mem_forward_zip, {1'b1, 5'd7, 32'h55});
        end
        cyc();
        sb_drained("rstmid_drain");
    endtask

    initial begin
        resetn          = 1'b0;
        es2ms_valid     = 1'b0;
        es2ms_bus       = '0;
        es_res_from_mul = 1'b0;
        mul_result      = '0;
        data_sram_rdata = '0;
        ws_allowin      = 1'b1;
        @(negedge clk);
        test_reset();
        test_load();
        test_stall();
        test_mul();
        test_back_to_back();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
